// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic single-transfer command master
//
// Purpose: accepts one command (adr/dat/we/sel) on a valid/ready port, runs
// one Wishbone classic cycle, waits for ack and returns read data/status on a
// valid/ready response port. One outstanding transfer at a time.
//
// Optional feature macro: WBM_TIMEOUT_EN. When defined, a cycle with no ack
// for TIMEOUT_CYCLES clocks is aborted with rsp_err=1. When undefined, the bus
// cycle waits for ack indefinitely and rsp_err is always 0.
//
// Ports:
//   wb_clk_i, wb_rst_i              clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_we/cmd_adr/cmd_dat/cmd_sel  command fields
//   rsp_valid/rsp_ready             response handshake
//   rsp_dat/rsp_err                 read data (0 for writes/errors), timeout flag
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o   Wishbone master outputs
//   wbm_dat_i/wbm_ack_i             Wishbone slave read data and acknowledge
module wb_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_adr,
  input  logic [DATA_W-1:0]   cmd_dat,
  input  logic [DATA_W/8-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i
);

  localparam int SEL_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timeout_hit;

`ifdef WBM_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT_CYCLES-1: the abort fires on the edge
  // that would have taken it to TIMEOUT_CYCLES.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == ST_BUS) && !wbm_ack_i &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (state_q == ST_BUS) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        // cmd_ready_q is low in the cycle after reset even though state is IDLE.
        if (cmd_valid && cmd_ready_q) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ack in the same cycle takes priority over the timeout.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - directed self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i;

  logic        auto_ack = 1'b0;
  logic        man_ack = 1'b0;
  logic        ack_q;

  int n_pass = 0;
  int n_total = 0;

  wb_cmd_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  // Registered slave: acks one cycle after it first sees stb, single-cycle pulse.
  always @(posedge clk) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= auto_ack & wbm_cyc_o & wbm_stb_o & ~ack_q;
  end
  assign wbm_ack_i = auto_ack ? ack_q : man_ack;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_we", wbm_we_o, 0);
    chk("rst_sel", wbm_sel_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_dat_o", wbm_dat_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // 1: write with 1-cycle registered ack
    auto_ack = 1'b1;
    cmd_we = 1'b1; cmd_adr = BASE; cmd_dat = 32'h3; cmd_sel = 4'hF; cmd_valid = 1'b1;
    tick();
    chk("t1_cyc", wbm_cyc_o, 1);
    chk("t1_stb", wbm_stb_o, 1);
    chk("t1_we", wbm_we_o, 1);
    chk("t1_adr", wbm_adr_o, BASE);
    chk("t1_dat_o", wbm_dat_o, 32'h3);
    chk("t1_sel", wbm_sel_o, 4'hF);
    chk("t1_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b0; cmd_adr = 32'hFFFF_FFFF;
    tick();
    chk("t1_cyc2", wbm_cyc_o, 1);
    chk("t1_adr_held", wbm_adr_o, BASE);
    tick();
    chk("t1_cyc_drop", wbm_cyc_o, 0);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_rsp_dat", rsp_dat, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_rsp_done", rsp_valid, 0);
    chk("t1_ready_back", cmd_ready, 1);
    chk("t1_adr_kept", wbm_adr_o, BASE);
    chk("t1_we_kept", wbm_we_o, 1);

    // 2: read, lingering ack
    auto_ack = 1'b0;
    cmd_we = 1'b0; cmd_adr = BASE; cmd_valid = 1'b1;
    tick();
    chk("t2_cyc", wbm_cyc_o, 1);
    chk("t2_we", wbm_we_o, 0);
    cmd_valid = 1'b0; wbm_dat_i = 32'h3; man_ack = 1'b1;
    tick();
    chk("t2_cyc_drop", wbm_cyc_o, 0);
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_dat", rsp_dat, 32'h3);
    wbm_dat_i = 32'hDEAD_BEEF;
    tick();
    chk("t2_linger_resp_valid", rsp_valid, 1);
    chk("t2_linger_resp_dat", rsp_dat, 32'h3);
    chk("t2_linger_resp_cyc", wbm_cyc_o, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t2_rsp_done", rsp_valid, 0);
    tick();
    chk("t2_linger_idle_cyc", wbm_cyc_o, 0);
    chk("t2_linger_idle_rsp", rsp_valid, 0);
    chk("t2_linger_idle_ready", cmd_ready, 1);
    man_ack = 1'b0;

    // 3: response back-pressure for 10 cycles
    cmd_we = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; wbm_dat_i = 32'h1234_5678; man_ack = 1'b1;
    tick();
    man_ack = 1'b0; wbm_dat_i = '0; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_rsp_valid", rsp_valid, 1);
      chk("t3_rsp_dat", rsp_dat, 32'h1234_5678);
      chk("t3_cmd_ready", cmd_ready, 0);
      chk("t3_cyc", wbm_cyc_o, 0);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t3_rsp_done", rsp_valid, 0);

    // 4: back-to-back writes, one transfer every 4 clocks
    auto_ack = 1'b1; cmd_we = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cmd_adr = BASE + 32'(4 * k);
      cmd_dat = 32'(k);
      tick();
      chk("t4_cyc", wbm_cyc_o, ((k % 4) < 2) ? 1 : 0);
      chk("t4_rsp_valid", rsp_valid, ((k % 4) == 2) ? 1 : 0);
      if ((k % 4) < 2) begin
        chk("t4_adr", wbm_adr_o, BASE + 32'(4 * (k & ~3)));
        chk("t4_dat_o", wbm_dat_o, 32'(k & ~3));
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;

    // 5: reset during an unacked strobe
    auto_ack = 1'b0; man_ack = 1'b0;
    cmd_we = 1'b1; cmd_adr = BASE + 32'h10; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t5_cyc", wbm_cyc_o, 1);
    tick();
    chk("t5_stb", wbm_stb_o, 1);
    rst = 1'b1;
    tick();
    chk("t5_rst_cyc", wbm_cyc_o, 0);
    chk("t5_rst_stb", wbm_stb_o, 0);
    chk("t5_rst_rsp_valid", rsp_valid, 0);
    chk("t5_rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    tick();
    chk("t5_ready_back", cmd_ready, 1);
    chk("t5_no_rsp", rsp_valid, 0);
    chk("t5_adr_cleared", wbm_adr_o, 0);
    auto_ack = 1'b1; wbm_dat_i = 32'hA5A5_0001;
    cmd_we = 1'b0; cmd_adr = BASE + 32'h20; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t5_new_cyc", wbm_cyc_o, 1);
    chk("t5_new_adr", wbm_adr_o, BASE + 32'h20);
    tick();
    tick();
    chk("t5_new_rsp_valid", rsp_valid, 1);
    chk("t5_new_rsp_dat", rsp_dat, 32'hA5A5_0001);
    chk("t5_new_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // 6: slave never acks
    auto_ack = 1'b0; man_ack = 1'b0; wbm_dat_i = 32'h5555_AAAA;
    cmd_we = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t6_cyc", wbm_cyc_o, 1);
`ifdef WBM_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t6_hold", wbm_cyc_o, 1);
    end
    tick();
    chk("t6_to_cyc", wbm_cyc_o, 0);
    chk("t6_to_rsp_valid", rsp_valid, 1);
    chk("t6_to_err", rsp_err, 1);
    chk("t6_to_dat", rsp_dat, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t6b_hold", wbm_cyc_o, 1);
    end
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("t6b_cyc", wbm_cyc_o, 0);
    chk("t6b_rsp_valid", rsp_valid, 1);
    chk("t6b_err", rsp_err, 0);
    chk("t6b_dat", rsp_dat, 32'h5555_AAAA);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_wait", wbm_cyc_o, 1);
    end
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("t6_cyc", wbm_cyc_o, 0);
    chk("t6_rsp_valid", rsp_valid, 1);
    chk("t6_err", rsp_err, 0);
    chk("t6_dat", rsp_dat, 32'h5555_AAAA);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t6_done", rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
